// File: rtl/ram_dual_port_clr_pkg.sv
// Shared types and helpers for the dual-port RAM with built-in clear engine.
package ram_pkg;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Address width that stays >= 1 even for the smallest legal depth.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_dual_port_clr_clear_ctrl.sv
// Clear engine: walks every address once after reset or on request, holding o_Busy meanwhile.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Clear,
  output logic          o_Busy,
  output logic          o_Clr_We,
  output logic [AW-1:0] o_Clr_Addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ram_state_e    state;
  logic [AW-1:0] cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state  <= RAM_CLEAR;
      cnt    <= '0;
      o_Busy <= 1'b1;
    end else begin
      case (state)
        RAM_CLEAR: begin
          // Requests arriving mid-clear are ignored; the walk always completes.
          if (cnt == LAST) begin
            state  <= RAM_READY;
            cnt    <= '0;
            o_Busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RAM_READY: begin
          if (i_Clear) begin
            state  <= RAM_CLEAR;
            cnt    <= '0;
            o_Busy <= 1'b1;
          end
        end
        default: begin
          state  <= RAM_CLEAR;
          cnt    <= '0;
          o_Busy <= 1'b1;
        end
      endcase
    end
  end

  // Busy is high exactly while in RAM_CLEAR, so it doubles as the clear write strobe.
  assign o_Clr_We   = o_Busy;
  assign o_Clr_Addr = cnt;

endmodule

// File: rtl/ram_dual_port_clr.sv
// Simple dual-port RAM with byte enables, registered read + valid strobe and a clear engine.
// Define RAM_OUT_REG_EN to add a second output register stage (read latency 2).
module ram_dual_port_clr
  import ram_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 256,
  parameter int               BYTE_W    = 8,
  parameter int               RDW_MODE  = RDW_READ_FIRST,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Wr_En,
  input  logic [clog2_safe(DEPTH)-1:0]  i_Wr_Addr,
  input  logic [WIDTH-1:0]              i_Wr_Data,
  input  logic [WIDTH/BYTE_W-1:0]       i_Wr_Be,
  input  logic                          i_Rd_En,
  input  logic [clog2_safe(DEPTH)-1:0]  i_Rd_Addr,
  output logic [WIDTH-1:0]              o_Rd_Data,
  output logic                          o_Rd_DV,
  input  logic                          i_Clear,
  output logic                          o_Busy
);

  localparam int AW  = clog2_safe(DEPTH);
  localparam int NBE = WIDTH / BYTE_W;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
`ifdef RAM_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [WIDTH-1:0] mem [DEPTH];

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_in, rd_in, wr_ok, rd_ok;
  logic [WIDTH-1:0] rd_old, merged, rd_word;
  logic [NBE-1:0]   lane_we;
  logic [AW-1:0]    mw_addr;
  logic [WIDTH-1:0] mw_data;

  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][WIDTH-1:0] dat_pipe;

  ram_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Clear    (i_Clear),
    .o_Busy     (o_Busy),
    .o_Clr_We   (clr_we),
    .o_Clr_Addr (clr_addr)
  );

  // A clear request in READY wins over any same-cycle user access.
  assign wr_in = {1'b0, i_Wr_Addr} < DEPTH_L;
  assign rd_in = {1'b0, i_Rd_Addr} < DEPTH_L;
  assign wr_ok = i_Wr_En && wr_in && !o_Busy && !i_Clear && !i_Rst;
  assign rd_ok = i_Rd_En && !o_Busy && !i_Clear && !i_Rst;

  always_comb begin
    rd_old = '0;
    if (rd_in) rd_old = mem[i_Rd_Addr];
  end

  for (genvar k = 0; k < NBE; k++) begin : g_lane
    assign merged[k*BYTE_W +: BYTE_W] = i_Wr_Be[k] ? i_Wr_Data[k*BYTE_W +: BYTE_W]
                                                   : rd_old[k*BYTE_W +: BYTE_W];
    assign lane_we[k] = clr_we | (wr_ok & i_Wr_Be[k]);
  end

  // Write-first bypass only matters when both ports hit the same in-range word.
  always_comb begin
    rd_word = rd_old;
    if (RDW_MODE == RDW_WRITE_FIRST && wr_ok && rd_in && i_Wr_Addr == i_Rd_Addr)
      rd_word = merged;
  end

  assign mw_addr = clr_we ? clr_addr : i_Wr_Addr;
  assign mw_data = clr_we ? CLEAR_VAL : i_Wr_Data;

  always_ff @(posedge i_Clk) begin
    for (int k = 0; k < NBE; k++)
      if (lane_we[k]) mem[mw_addr][k*BYTE_W +: BYTE_W] <= mw_data[k*BYTE_W +: BYTE_W];
  end

  // Later stages advance regardless of o_Busy so an accepted read always completes.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_ok;
      if (rd_ok) dat_pipe[1] <= rd_word;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign o_Rd_Data = dat_pipe[STAGES];
  assign o_Rd_DV   = vld_pipe[STAGES];

endmodule

// File: tb/tb_ram_dual_port_clr.sv
// Scoreboard bench for ram_dual_port_clr: random and directed traffic against an array model.
module tb_ram_dual_port_clr;

  localparam int          WIDTH  = 16;
  localparam int          DEPTH  = 256;
  localparam int          BYTE_W = 8;
  localparam int          NBE    = WIDTH / BYTE_W;
  localparam int          RDW    = 0;
  localparam logic [15:0] CLRV   = 16'hC1A0;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             i_Clk = 1'b0;
  logic             i_Rst = 1'b1;
  logic             i_Wr_En = 1'b0;
  logic [7:0]       i_Wr_Addr = '0;
  logic [15:0]      i_Wr_Data = '0;
  logic [NBE-1:0]   i_Wr_Be = '0;
  logic             i_Rd_En = 1'b0;
  logic [7:0]       i_Rd_Addr = '0;
  logic [15:0]      o_Rd_Data;
  logic             o_Rd_DV;
  logic             i_Clear = 1'b0;
  logic             o_Busy;

  ram_dual_port_clr #(
    .WIDTH (WIDTH), .DEPTH (DEPTH), .BYTE_W (BYTE_W), .RDW_MODE (RDW), .CLEAR_VAL (CLRV)
  ) dut (
    .i_Clk (i_Clk), .i_Rst (i_Rst),
    .i_Wr_En (i_Wr_En), .i_Wr_Addr (i_Wr_Addr), .i_Wr_Data (i_Wr_Data), .i_Wr_Be (i_Wr_Be),
    .i_Rd_En (i_Rd_En), .i_Rd_Addr (i_Rd_Addr), .o_Rd_Data (o_Rd_Data), .o_Rd_DV (o_Rd_DV),
    .i_Clear (i_Clear), .o_Busy (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;

  // Reference: the memory contents and how much of a clear remains.
  logic [15:0] mdl [DEPTH];
  bit          busy_m;
  int          clr_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit wr, input logic [7:0] wa, input logic [15:0] wd,
                      input logic [NBE-1:0] be, input bit rd, input logic [7:0] ra, input bit clr);
    logic [15:0] nw;
    exp_t e;
    i_Wr_En = wr; i_Wr_Addr = wa; i_Wr_Data = wd; i_Wr_Be = be;
    i_Rd_En = rd; i_Rd_Addr = ra; i_Clear = clr;
    check("busy", {31'd0, o_Busy}, {31'd0, busy_m});
    if (busy_m) begin
      mdl[clr_cnt] = CLRV;
      clr_cnt++;
      if (clr_cnt == DEPTH) busy_m = 0;
    end else if (clr) begin
      busy_m  = 1;
      clr_cnt = 0;
    end else begin
      nw = mdl[wa];
      for (int k = 0; k < NBE; k++)
        if (be[k]) nw[k*BYTE_W +: BYTE_W] = wd[k*BYTE_W +: BYTE_W];
      if (rd) begin
        e.due  = cyc + LAT;
        e.data = (RDW == 1 && wr && wa == ra) ? nw : mdl[ra];
        sb.push_back(e);
      end
      if (wr) mdl[wa] = nw;
    end
    @(posedge i_Clk); #1;
    i_Wr_En = 0; i_Rd_En = 0; i_Clear = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'd0, 16'd0, '0, 0, 8'd0, 0);
  endtask

  task automatic do_reset();
    i_Rst = 1; i_Wr_En = 0; i_Rd_En = 0; i_Clear = 0;
    @(posedge i_Clk); #1;
    i_Rst = 0;
    busy_m = 1; clr_cnt = 0;
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (o_Busy === 1'b1 && n < 1000) begin
      idle(1);
      n++;
    end
    check(name, n, DEPTH);
  endtask

  // Monitor: every strobe must match the oldest pending read and arrive on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_Clk);
      if (o_Rd_DV === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_dv", {31'd0, o_Rd_DV}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rd_data", {16'd0, o_Rd_Data}, {16'd0, e.data});
          check("rd_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;
    busy_m = 1; clr_cnt = 0;
    #1;
    repeat (2) begin @(posedge i_Clk); #1; end
    do_reset();
    check("reset_dv", {31'd0, o_Rd_DV}, 32'd0);
    check("reset_data", {16'd0, o_Rd_Data}, 32'd0);
    check("reset_busy", {31'd0, o_Busy}, 32'd1);

    // Clear length after reset, then cleared contents at both ends.
    wait_clear("t1_clear_len");
    step(0, 8'd0, 16'd0, '0, 1, 8'h00, 0);
    step(0, 8'd0, 16'd0, '0, 1, 8'hFF, 0);
    idle(3);

    // Byte-lane merge.
    step(1, 8'd5, 16'hBEEF, 2'b11, 0, 8'd0, 0);
    step(1, 8'd5, 16'h0012, 2'b01, 0, 8'd0, 0);
    step(0, 8'd0, 16'd0, '0, 1, 8'd5, 0);
    idle(3);

    // Same-address read/write collision.
    step(1, 8'd7, 16'hAAAA, 2'b11, 0, 8'd0, 0);
    step(1, 8'd7, 16'h1234, 2'b11, 1, 8'd7, 0);
    idle(3);

    // Clear beats a same-cycle write and read.
    step(1, 8'd3, 16'h5555, 2'b11, 0, 8'd0, 0);
    step(1, 8'd3, 16'h1111, 2'b11, 1, 8'd3, 1);
    check("t4_busy_next", {31'd0, o_Busy}, 32'd1);
    wait_clear("t4_clear_len");
    step(0, 8'd0, 16'd0, '0, 1, 8'd3, 0);
    idle(3);

    // Reset part way through a clear restarts it.
    do_reset();
    idle(100);
    do_reset();
    wait_clear("t5_restart_len");

    // Back-to-back reads of 0..15.
    for (int a = 0; a < 16; a++) step(1, a[7:0], 16'($urandom), 2'b11, 0, 8'd0, 0);
    for (int a = 0; a < 16; a++) step(0, 8'd0, 16'd0, '0, 1, a[7:0], 0);
    idle(4);

    // Random traffic on a narrow address window to provoke collisions; rare clears.
    for (int i = 0; i < 500; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom),
           NBE'($urandom), bit'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
           ($urandom_range(0, 299) == 0));
    end
    idle(LAT + 3);
    check("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Overall time bound: the run above needs a few thousand cycles.
  initial begin
    #500000;
    $display("FAIL timeout: cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
